// File: rtl/phy_rx_unstriper_if.sv
// Bus bundle for the two-lane receive un-striper: two byte lanes in,
// one reassembled word stream plus sticky overflow out.
interface phy_rx_unstriper_if;
  logic [7:0]  data_in_0;
  logic        valid_in0;
  logic [7:0]  data_in_1;
  logic        valid_in1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        overflow;

  modport master (
    output data_in_0, valid_in0, data_in_1, valid_in1,
    input  data_out, valid_out, overflow
  );

  modport slave (
    input  data_in_0, valid_in0, data_in_1, valid_in1,
    output data_out, valid_out, overflow
  );
endinterface

// File: rtl/phy_rx_unstriper.sv
// Packs two MSB-first byte lanes into 32-bit words, buffers each lane in a
// small FIFO, and re-interleaves the words lane 0 first, then alternating.
module phy_rx_unstriper #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_4f,
  input  logic               reset,
  phy_rx_unstriper_if.slave  bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0][7:0]   w_din;
  logic [1:0]        w_vin;
  logic [1:0]        w_empty;
  logic [1:0][31:0]  w_head;
  logic [1:0]        w_pop;
  logic [1:0]        w_drop;

  logic [31:0]       r_data_out;
  logic              r_valid_out;
  logic              r_overflow;

  assign w_din = {bus.data_in_1, bus.data_in_0};
  assign w_vin = {bus.valid_in1, bus.valid_in0};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [1:0]  r_cnt;
    logic [23:0] r_part;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_push;
    logic        w_full;
    logic        w_wr;

    assign w_push    = w_vin[g] && (r_cnt == 2'd3);
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    // A pop on the same edge frees the head slot, so a push into a full FIFO is still accepted.
    assign w_wr      = w_push && (!w_full || w_pop[g]);
    assign w_drop[g] = w_push && w_full && !w_pop[g];
    assign w_empty[g] = (r_wp == r_rp);
    assign w_head[g]  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_part <= '0;
      end else if (w_vin[g]) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0:    r_part[23:16] <= w_din[g];
          2'd1:    r_part[15:8]  <= w_din[g];
          2'd2:    r_part[7:0]   <= w_din[g];
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_wr)
          r_wp <= r_wp + 1'b1;
        if (w_pop[g])
          r_rp <= r_rp + 1'b1;
      end
    end

    always_ff @(posedge clk_4f) begin
      if (w_wr)
        r_mem[r_wp[AW-1:0]] <= {r_part, w_din[g]};
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset)
      r_state <= SEL0;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEL0:    if (!w_empty[0]) w_state_nxt = SEL1;
      SEL1:    if (!w_empty[1]) w_state_nxt = SEL0;
      default: w_state_nxt = SEL0;
    endcase
  end

  always_comb begin
    w_pop    = '0;
    w_pop[0] = (r_state == SEL0) && !w_empty[0];
    w_pop[1] = (r_state == SEL1) && !w_empty[1];
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid_out <= |w_pop;
      if (|w_pop)
        r_data_out <= w_pop[1] ? w_head[1] : w_head[0];
      r_overflow <= r_overflow | (|w_drop);
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_phy_rx_unstriper.sv
// Directed and randomized bench for phy_rx_unstriper; output words are
// collected on the falling edge and compared against a lane-word model.
module tb_phy_rx_unstriper;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  phy_rx_unstriper_if bus ();

  phy_rx_unstriper #(.FIFO_DEPTH(4)) dut (
    .clk_4f (clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && bus.valid_out === 1'b1)
      got_q.push_back(bus.data_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    @(negedge clk);
    bus.valid_in0 = v0;
    bus.data_in_0 = v0 ? d0 : 8'($urandom);
    bus.valid_in1 = v1;
    bus.data_in_1 = v1 ? d1 : 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    return 8'(w >> (24 - 8 * b));
  endfunction

  task automatic cmp_stream(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_streams();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b0q[$];
    logic [7:0]  b1q[$];
    logic        v0;
    logic        v1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          n;
    int          guard;

    total = 0;
    bad   = 0;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.data_in_0 = '0;
    bus.data_in_1 = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // basic pair, cycle exact
    clear_streams();
    for (int b = 0; b < 4; b++)
      drive(1'b1, byte_of(32'hDEADBEEF, b), 1'b1, byte_of(32'h01234567, b));
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pair_lat_v", 32'(bus.valid_out), 32'h0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pair_w0_v", 32'(bus.valid_out), 32'h1);
    chk("pair_w0_d", bus.data_out, 32'hDEADBEEF);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pair_w1_v", 32'(bus.valid_out), 32'h1);
    chk("pair_w1_d", bus.data_out, 32'h01234567);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("pair_end_v", 32'(bus.valid_out), 32'h0);
    chk("pair_hold_d", bus.data_out, 32'h01234567);

    // ordering under skew: lane 1 completes 8 cycles before lane 0
    clear_streams();
    for (int b = 0; b < 4; b++)
      drive(1'b0, 8'h00, 1'b1, byte_of(32'h11111111, b));
    idle(4);
    for (int b = 0; b < 4; b++)
      drive(1'b1, byte_of(32'h22222222, b), 1'b0, 8'h00);
    chk("skew_hold", 32'(got_q.size()), 32'h0);
    idle(6);
    exp_q = '{32'h22222222, 32'h11111111};
    cmp_stream("skew");

    // gapped bytes on lane 0, then a lane-1 word to rebalance the selector
    clear_streams();
    drive(1'b1, 8'hAA, 1'b0, 8'h00);
    idle(3);
    drive(1'b1, 8'hBB, 1'b0, 8'h00);
    drive(1'b1, 8'hCC, 1'b0, 8'h00);
    idle(1);
    chk("gap_quiet", 32'(got_q.size()), 32'h0);
    drive(1'b1, 8'hDD, 1'b0, 8'h00);
    idle(5);
    exp_q = '{32'hAABBCCDD};
    cmp_stream("gap");
    clear_streams();
    for (int b = 0; b < 4; b++)
      drive(1'b0, 8'h00, 1'b1, byte_of(32'h33333333, b));
    idle(4);
    exp_q = '{32'h33333333};
    cmp_stream("rebal");

    // overflow: five lane-1 words into a 4-deep FIFO with lane 0 idle
    clear_streams();
    for (int k = 1; k <= 5; k++) begin
      for (int b = 0; b < 4; b++)
        drive(1'b0, 8'h00, 1'b1, byte_of(32'(k), b));
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      chk($sformatf("ovf_after_%0d", k), 32'(bus.overflow), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("ovf_quiet", 32'(got_q.size()), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      for (int b = 0; b < 4; b++)
        drive(1'b1, byte_of(32'hC0DE0000 + 32'(k), b), 1'b0, 8'h00);
      exp_q.push_back(32'hC0DE0000 + 32'(k));
      exp_q.push_back(32'(k));
    end
    idle(12);
    cmp_stream("ovf");
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);

    // reset mid-word with traffic
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    drive(1'b1, 8'h66, 1'b0, 8'h00);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_data", bus.data_out, 32'h0);
    chk("mrst_valid", 32'(bus.valid_out), 32'h0);
    chk("mrst_ovf", 32'(bus.overflow), 32'h0);
    @(negedge clk);
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    reset = 1'b0;
    clear_streams();
    for (int b = 0; b < 4; b++)
      drive(1'b1, byte_of(32'h12345678, b), 1'b1, byte_of(32'h9ABCDEF0, b));
    idle(6);
    exp_q = '{32'h12345678, 32'h9ABCDEF0};
    cmp_stream("mrst");

    // randomized rounds: equal word counts per lane, independent random gaps
    for (int r = 0; r < 6; r++) begin
      clear_streams();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        exp_q.push_back(w);
        for (int b = 0; b < 4; b++) b0q.push_back(byte_of(w, b));
        w = $urandom;
        exp_q.push_back(w);
        for (int b = 0; b < 4; b++) b1q.push_back(byte_of(w, b));
      end
      // lane words interleave lane 0 first: reorder pairs pushed as (l0,l1)
      guard = 0;
      while ((b0q.size() != 0 || b1q.size() != 0) && guard < 400) begin
        v0 = (b0q.size() != 0) && ($urandom_range(0, 2) != 0);
        v1 = (b1q.size() != 0) && ($urandom_range(0, 2) != 0);
        d0 = v0 ? b0q.pop_front() : 8'h00;
        d1 = v1 ? b1q.pop_front() : 8'h00;
        drive(v0, d0, v1, d1);
        guard++;
      end
      chk($sformatf("rnd%0d_feed", r), 32'(b0q.size() + b1q.size()), 32'h0);
      b0q.delete();
      b1q.delete();
      idle(12);
      cmp_stream($sformatf("rnd%0d", r));
    end
    chk("rnd_ovf", 32'(bus.overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
